// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier with valid/ready handshakes.
// Also contains the 16-bit ripple add/sub datapath that the multiplier drives.

module Sixteen_b_full_adder (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        X,
   input  logic        c_in,
   output logic [15:0] S,
   output logic        c_out
);

   logic [15:0] bx;
   logic        carry;

   // X selects subtraction by inverting B; the caller supplies the matching c_in.
   always_comb begin
      bx    = B ^ {16{X}};
      carry = c_in;
      S     = '0;
      for (int i = 0; i < 16; i++) begin
         S[i]  = A[i] ^ bx[i] ^ carry;
         carry = (A[i] & bx[i]) | (carry & (A[i] ^ bx[i]));
      end
      c_out = carry;
   end

endmodule

module shift_add_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 out_zero,
   output logic                 busy
);

   generate
      if (WIDTH != 8) begin : g_width_check
         $error("shift_add_multiplier supports WIDTH == 8 only");
      end
   endgenerate

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [2*WIDTH-1:0] p;
   logic [2:0]         cnt;
   logic [2*WIDTH-1:0] sum;
   logic               add_cout;
   logic [2*WIDTH-1:0] p_next;

   Sixteen_b_full_adder u_adder (
      .A     (p),
      .B     (a_sh),
      .X     (1'b0),
      .c_in  (1'b0),
      .S     (sum),
      .c_out (add_cout)
   );

   always_comb begin
      p_next = b_sh[0] ? sum : p;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         a_sh        <= '0;
         b_sh        <= '0;
         p           <= '0;
         cnt         <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_product <= '0;
         out_zero    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  a_sh     <= {{WIDTH{1'b0}}, in_a};
                  b_sh     <= in_b;
                  p        <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= StBusy;
               end
            end
            StBusy: begin
               p    <= p_next;
               a_sh <= a_sh << 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + 3'd1;
               // Fixed eight iterations; no early exit when b_sh empties.
               if (cnt == 3'd7) begin
                  busy        <= 1'b0;
                  out_valid   <= 1'b1;
                  out_product <= p_next;
                  out_zero    <= (p_next == '0);
                  state       <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
